// File: rtl/alu32_arbiter.sv
// alu32_arbiter: shares one external alu32/zero32 datapath between NREQ
// requesters. One operation is in flight at a time. It is accepted over a
// valid/ready request handshake and executed from registered operands. The
// result and zero flag are captured, then returned to the winning requester
// over a valid/ready response handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_a, req_b, req_op  packed per-requester operands/opcode (slot i at i*W / i*OPW)
//   alu_a, alu_b, alu_op  registered operands to the shared ALU
//   alu_result, alu_zero  combinational ALU result and its zero32 flag
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_result, rsp_zero  captured result and zero flag
//   busy                  registered, high whenever the FSM is not IDLE
module alu32_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int OPW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [OPW-1:0]    alu_op,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [IDW-1:0]  ptr_r, id_r, win_s, idx_s, ptr_nxt_s;
  logic            found_s;
  logic [NREQ-1:0] grant_s, owner_s;
  logic            req_fire_s, rsp_fire_s;
  logic [W-1:0]    sel_a_s, sel_b_s;
  logic [OPW-1:0]  sel_op_s;
  logic [W-1:0]    a_r, b_r, result_r;
  logic [OPW-1:0]  op_r;
  logic            zero_r, busy_r;
  logic [NREQ-1:0] rsp_valid_r;

  // Round-robin search from ptr_r and operand mux for the winning slot.
  always_comb begin
    found_s  = 1'b0;
    win_s    = '0;
    idx_s    = '0;
    grant_s  = '0;
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_s == IDW'(i)) begin
        sel_a_s  = req_a[i*W +: W];
        sel_b_s  = req_b[i*W +: W];
        sel_op_s = req_op[i*OPW +: OPW];
      end else begin
        sel_a_s  = sel_a_s;
      end
    end
  end

  // Owner decode of the latched id and the pointer value after this owner.
  always_comb begin
    owner_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_s[i] = (id_r == IDW'(i));
    end
    if (id_r == IDW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = id_r + IDW'(1);
    end
  end

  // Next-state logic and the combinational request grant.
  always_comb begin
    state_s    = state_r;
    req_ready  = '0;
    req_fire_s = 1'b0;
    rsp_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Grant is suppressed while reset is asserted so nothing looks accepted.
        if (found_s && rst_n) begin
          req_ready  = grant_s;
          req_fire_s = 1'b1;
          state_s    = EXEC;
        end else begin
          state_s    = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      RESP: begin
        // Only the owner's rsp_ready is looked at.
        if (rsp_ready[id_r]) begin
          rsp_fire_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s    = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with busy registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Operand latch, result capture, response valid and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= '0;
      id_r        <= '0;
      ptr_r       <= '0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      rsp_valid_r <= '0;
    end else begin
      // Operands only change on acceptance so the ALU inputs stay quiet otherwise.
      if (req_fire_s) begin
        a_r  <= sel_a_s;
        b_r  <= sel_b_s;
        op_r <= sel_op_s;
        id_r <= win_s;
      end else begin
        a_r  <= a_r;
      end
      if (state_r == EXEC) begin
        result_r    <= alu_result;
        zero_r      <= alu_zero;
        rsp_valid_r <= owner_s;
      end else if (rsp_fire_s) begin
        rsp_valid_r <= '0;
        ptr_r       <= ptr_nxt_s;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign alu_op     = op_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = result_r;
  assign rsp_zero   = zero_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed and randomised bench for alu32_arbiter with a behavioural ALU
// (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT) on the shared port.
module tb_alu32_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [15:0]  req_op;
  logic [31:0]  alu_a, alu_b, alu_result;
  logic [3:0]   alu_op;
  logic         alu_zero;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_result;
  logic         rsp_zero;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  alu32_arbiter #(.NREQ(4), .W(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0: alu_f = a + b;
      4'd1: alu_f = a - b;
      4'd2: alu_f = a & b;
      4'd3: alu_f = a | b;
      4'd4: alu_f = a ^ b;
      4'd5: alu_f = a << b[4:0];
      4'd6: alu_f = a >> b[4:0];
      4'd7: alu_f = {31'd0, ($signed(a) < $signed(b))};
      default: alu_f = 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*4 +: 4]  = op;
  endtask

  // Sole requester i, fixed 3-cycle op with rsp_ready high; ends at an IDLE negedge.
  task automatic drive_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    set_slot(i, a, b, op);
    req_valid = 4'b0001 << i;
    rsp_ready = 4'hF;
    @(posedge clk); @(negedge clk);
    req_valid = 4'h0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 4'hF;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL rst_req_ready got=%h exp=%h", req_ready, 4'h0); end
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL rst_rsp_valid got=%h exp=%h", rsp_valid, 4'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=%b", busy, 1'b0); end
    checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin failures++; $display("FAIL rst_alu got=%h exp=%h", {alu_a, alu_b, alu_op}, 68'd0); end
    checks++; if ({rsp_result, rsp_zero} !== 33'd0) begin failures++; $display("FAIL rst_rsp got=%h exp=%h", {rsp_result, rsp_zero}, 33'd0); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=%b", req_ready, 4'b0001); end
    req_valid = 4'h0;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_drop_busy got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic run_single(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input logic [31:0] exp_r, input logic exp_z);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    set_slot(i, a, b, op);
    req_valid = oh; rsp_ready = oh;
    #1;
    checks++; if (req_ready !== oh) begin failures++; $display("FAIL single_grant got=%b exp=%b", req_ready, oh); end
    @(posedge clk); @(negedge clk);
    req_valid = 4'h0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_exec_busy got=%b exp=%b", busy, 1'b1); end
    checks++; if (alu_a !== a) begin failures++; $display("FAIL single_alu_a got=%h exp=%h", alu_a, a); end
    checks++; if (alu_b !== b) begin failures++; $display("FAIL single_alu_b got=%h exp=%h", alu_b, b); end
    checks++; if (alu_op !== op) begin failures++; $display("FAIL single_alu_op got=%h exp=%h", alu_op, op); end
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL single_exec_rsp got=%b exp=%b", rsp_valid, 4'h0); end
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== oh) begin failures++; $display("FAIL single_rsp_valid got=%b exp=%b", rsp_valid, oh); end
    checks++; if (rsp_result !== exp_r) begin failures++; $display("FAIL single_result got=%h exp=%h", rsp_result, exp_r); end
    checks++; if (rsp_zero !== exp_z) begin failures++; $display("FAIL single_zero got=%b exp=%b", rsp_zero, exp_z); end
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL single_rsp_done got=%b exp=%b", rsp_valid, 4'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_single_op;
    run_single(2, 32'h0000_0005, 32'h0000_0005, OP_SUB, 32'h0000_0000, 1'b1);
    run_single(0, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1);
    run_single(3, 32'h8000_0000, 32'h0000_0000, OP_OR,  32'h8000_0000, 1'b0);
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_r [4];
    int gk, rk, last_c;
    exp_r[0] = 32'h11; exp_r[1] = 32'h22; exp_r[2] = 32'h33; exp_r[3] = 32'h44;
    set_slot(0, 32'h10, 32'h1, OP_ADD);
    set_slot(1, 32'h20, 32'h2, OP_ADD);
    set_slot(2, 32'h30, 32'h3, OP_ADD);
    set_slot(3, 32'h40, 32'h4, OP_ADD);
    req_valid = 4'hF; rsp_ready = 4'hF;
    gk = 0; rk = 0; last_c = 0;
    #1;
    for (int c = 0; c < 40 && rk < 8; c++) begin
      if (req_ready !== 4'h0) begin
        checks++; if (req_ready !== (4'b0001 << (gk % 4))) begin failures++; $display("FAIL rr_grant_%0d got=%b exp=%b", gk, req_ready, 4'b0001 << (gk % 4)); end
        if (gk > 0) begin
          checks++; if (c - last_c !== 3) begin failures++; $display("FAIL rr_period_%0d got=%0d exp=%0d", gk, c - last_c, 3); end
        end
        last_c = c; gk++;
      end
      if (rsp_valid !== 4'h0) begin
        checks++; if (rsp_valid !== (4'b0001 << (rk % 4))) begin failures++; $display("FAIL rr_owner_%0d got=%b exp=%b", rk, rsp_valid, 4'b0001 << (rk % 4)); end
        checks++; if (rsp_result !== exp_r[rk % 4]) begin failures++; $display("FAIL rr_result_%0d got=%h exp=%h", rk, rsp_result, exp_r[rk % 4]); end
        rk++;
      end
      @(negedge clk); #1;
    end
    req_valid = 4'h0;
    checks++; if (rk !== 8) begin failures++; $display("FAIL rr_timeout got=%0d exp=%0d", rk, 8); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back;
    set_slot(1, 32'h1234_5678, 32'h0000_00FF, OP_AND);
    set_slot(3, 32'hAAAA_AAAA, 32'hAAAA_AAAA, OP_XOR);
    req_valid = 4'b1010; rsp_ready = 4'h0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=%b", req_ready, 4'b0010); end
    @(posedge clk); @(negedge clk);
    req_valid = 4'b1000;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL bp_valid_%0d got=%b exp=%b", c, rsp_valid, 4'b0010); end
      checks++; if (rsp_result !== 32'h0000_0078) begin failures++; $display("FAIL bp_result_%0d got=%h exp=%h", c, rsp_result, 32'h0000_0078); end
      checks++; if (rsp_zero !== 1'b0) begin failures++; $display("FAIL bp_zero_%0d got=%b exp=%b", c, rsp_zero, 1'b0); end
      checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL bp_req_ready_%0d got=%b exp=%b", c, req_ready, 4'h0); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy_%0d got=%b exp=%b", c, busy, 1'b1); end
      // A non-owner ready must not complete the response.
      rsp_ready = (c == 2) ? 4'b1101 : 4'h0;
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 4'b0010;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=%b", busy, 1'b0); end
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL b2b_rsp_clear got=%b exp=%b", rsp_valid, 4'h0); end
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL b2b_grant got=%b exp=%b", req_ready, 4'b1000); end
    @(posedge clk); @(negedge clk);
    req_valid = 4'h0; rsp_ready = 4'hF;
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 4'b1000) begin failures++; $display("FAIL b2b_valid got=%b exp=%b", rsp_valid, 4'b1000); end
    checks++; if ({rsp_result, rsp_zero} !== {32'h0, 1'b1}) begin failures++; $display("FAIL b2b_result got=%h exp=%h", {rsp_result, rsp_zero}, {32'h0, 1'b1}); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid;
    drive_op(1, 32'h1, 32'h2, OP_ADD);
    set_slot(2, 32'h9, 32'h3, OP_SUB);
    req_valid = 4'b0100; rsp_ready = 4'hF;
    @(posedge clk); @(negedge clk);
    req_valid = 4'h0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_exec_busy got=%b exp=%b", busy, 1'b1); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL rm_exec_rsp got=%b exp=%b", rsp_valid, 4'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_exec_state got=%b exp=%b", busy, 1'b0); end
    checks++; if (alu_a !== 32'h0) begin failures++; $display("FAIL rm_exec_alu_a got=%h exp=%h", alu_a, 32'h0); end
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL rm_exec_rsp2 got=%b exp=%b", rsp_valid, 4'h0); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 5'd0) begin failures++; $display("FAIL rm_exec_release got=%b exp=%b", {rsp_valid, busy}, 5'd0); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rm_exec_ptr got=%b exp=%b", req_ready, 4'b0001); end
    req_valid = 4'h0;
    @(negedge clk);
    drive_op(1, 32'h1, 32'h2, OP_ADD);
    set_slot(3, 32'h7, 32'h8, OP_ADD);
    req_valid = 4'b1000; rsp_ready = 4'h0;
    @(posedge clk); @(negedge clk);
    req_valid = 4'h0;
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 4'b1000) begin failures++; $display("FAIL rm_resp_reached got=%b exp=%b", rsp_valid, 4'b1000); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 5'd0) begin failures++; $display("FAIL rm_resp_state got=%b exp=%b", {rsp_valid, busy}, 5'd0); end
    checks++; if ({rsp_result, rsp_zero} !== 33'd0) begin failures++; $display("FAIL rm_resp_data got=%h exp=%h", {rsp_result, rsp_zero}, 33'd0); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL rm_resp_release got=%b exp=%b", rsp_valid, 4'h0); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rm_resp_ptr got=%b exp=%b", req_ready, 4'b0001); end
    req_valid = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int ptr_m, w, idx;
    logic [3:0] mask, oh;
    logic [31:0] a, b, exp_r;
    logic [3:0] op;
    logic done;
    ptr_m = 0;
    for (int n = 0; n < 500; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        op = 4'($urandom_range(0, 7));
        set_slot(i, a, b, op);
      end
      w = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (ptr_m + k) % 4;
        if (w < 0 && mask[idx]) w = idx;
      end
      oh = 4'b0001 << w;
      exp_r = alu_f(req_a[w*32 +: 32], req_b[w*32 +: 32], req_op[w*4 +: 4]);
      req_valid = mask; rsp_ready = 4'($urandom_range(0, 15));
      #1;
      checks++; if (req_ready !== oh) begin failures++; $display("FAIL rnd_grant_%0d got=%b exp=%b", n, req_ready, oh); end
      @(posedge clk); @(negedge clk);
      req_valid = 4'h0;
      checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL rnd_exec_rsp_%0d got=%b exp=%b", n, rsp_valid, 4'h0); end
      @(posedge clk); @(negedge clk);
      done = 1'b0;
      for (int c = 0; c < 8 && !done; c++) begin
        checks++; if (!$onehot0(rsp_valid)) begin failures++; $display("FAIL rnd_onehot_%0d got=%b exp=onehot0", n, rsp_valid); end
        checks++; if (rsp_valid !== oh) begin failures++; $display("FAIL rnd_owner_%0d got=%b exp=%b", n, rsp_valid, oh); end
        checks++; if (rsp_result !== exp_r) begin failures++; $display("FAIL rnd_result_%0d got=%h exp=%h", n, rsp_result, exp_r); end
        checks++; if (rsp_zero !== (exp_r == 32'd0)) begin failures++; $display("FAIL rnd_zero_%0d got=%b exp=%b", n, rsp_zero, exp_r == 32'd0); end
        checks++; if (rsp_zero !== (rsp_result == 32'd0)) begin failures++; $display("FAIL rnd_zero_consistent_%0d got=%b exp=%b", n, rsp_zero, rsp_result == 32'd0); end
        rsp_ready = 4'($urandom_range(0, 15));
        if (c == 7) rsp_ready[w] = 1'b1;
        done = rsp_ready[w];
        @(posedge clk); @(negedge clk);
      end
      checks++; if ({rsp_valid, busy} !== 5'd0) begin failures++; $display("FAIL rnd_done_%0d got=%b exp=%b", n, {rsp_valid, busy}, 5'd0); end
      ptr_m = (w + 1) % 4;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'h0; rsp_ready = 4'h0;
    req_a = 128'd0; req_b = 128'd0; req_op = 16'd0;
    test_reset;
    test_single_op;
    test_round_robin;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
